// File: rtl/fft_stage_sequencer.sv
// Stage/iteration sequencer for a radix-2 in-place FFT butterfly datapath.
// Optional bit-reversed input load phase is enabled by defining FFT_SEQ_BITREV_EN.
module fft_stage_sequencer #(
    parameter int LOG2_N     = 6,
    parameter int BF_LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stall,
    output logic                      iteration_strobe,
    output logic [LOG2_N-2:0]         iteration_count,
    output logic [$clog2(LOG2_N)-1:0] stage_count,
    output logic                      stage_strobe,
    output logic [LOG2_N-1:0]         addr_a,
    output logic [LOG2_N-1:0]         addr_b,
    output logic [LOG2_N-2:0]         twiddle_idx,
    output logic                      bank_sel,
    output logic                      busy,
    output logic                      done
`ifdef FFT_SEQ_BITREV_EN
    ,
    output logic                      load_strobe,
    output logic [LOG2_N-1:0]         load_addr
`endif
);

    localparam int N      = 1 << LOG2_N;
    localparam int HALF_N = N / 2;
    localparam int IW     = LOG2_N - 1;
    localparam int SW     = $clog2(LOG2_N);
    localparam int DW     = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    localparam logic [IW-1:0] ITER_LAST  = IW'(HALF_N - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2_N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LATENCY - 1);

`ifdef FFT_SEQ_BITREV_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_LOAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            bank_q, bank_d;
    logic [DW-1:0]   drain_q, drain_d;
`ifdef FFT_SEQ_BITREV_EN
    logic [LOG2_N-1:0] load_q, load_d;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            stage_q <= '0;
            bank_q  <= 1'b0;
            drain_q <= '0;
`ifdef FFT_SEQ_BITREV_EN
            load_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            stage_q <= stage_d;
            bank_q  <= bank_d;
            drain_q <= drain_d;
`ifdef FFT_SEQ_BITREV_EN
            load_q  <= load_d;
`endif
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        iter_d           = iter_q;
        stage_d          = stage_q;
        bank_d           = bank_q;
        drain_d          = drain_q;
        iteration_strobe = 1'b0;
        stage_strobe     = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
        load_d           = load_q;
        load_strobe      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_d  = '0;
                    stage_d = '0;
                    drain_d = '0;
`ifdef FFT_SEQ_BITREV_EN
                    load_d  = '0;
                    state_d = S_LOAD;
`else
                    state_d = S_ISSUE;
`endif
                end
            end
`ifdef FFT_SEQ_BITREV_EN
            S_LOAD: begin
                busy        = 1'b1;
                load_strobe = !stall;
                if (!stall) begin
                    if (load_q == LOG2_N'(N - 1)) begin
                        load_d  = '0;
                        // Input samples land in bank 0, so stage 0 must read it.
                        bank_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        load_d = load_q + LOG2_N'(1);
                    end
                end
            end
`endif
            S_ISSUE: begin
                busy             = 1'b1;
                iteration_strobe = !stall;
                if (!stall) begin
                    if (iter_q == ITER_LAST) begin
                        iter_d  = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        iter_d = iter_q + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    stage_strobe = 1'b1;
                    drain_d      = '0;
                    bank_d       = !bank_q;
                    stage_d      = stage_q + SW'(1);
                    state_d      = (stage_q == STAGE_LAST) ? S_DONE : S_ISSUE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [LOG2_N-1:0] iter_ext, half, pos, base;

    // Butterfly pair: upper leg keeps bit s clear, lower leg sets it.
    always_comb begin
        iter_ext    = {1'b0, iter_q};
        half        = LOG2_N'(1) << stage_q;
        pos         = iter_ext & (half - LOG2_N'(1));
        base        = ((iter_ext >> stage_q) << (stage_q + SW'(1))) | pos;
        addr_a      = '0;
        addr_b      = '0;
        twiddle_idx = '0;
        if (state_q == S_ISSUE) begin
            addr_a      = base;
            addr_b      = base + half;
            twiddle_idx = IW'(pos << (SW'(LOG2_N - 1) - stage_q));
        end
    end

`ifdef FFT_SEQ_BITREV_EN
    always_comb begin
        load_addr = '0;
        for (int b = 0; b < LOG2_N; b++) begin
            load_addr[b] = load_q[LOG2_N-1-b];
        end
    end
`endif

    assign iteration_count = iter_q;
    assign stage_count     = stage_q;
    assign bank_sel        = bank_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: address vector table plus multi-cycle
// sequences (full sweep, stalls, mid-transform reset, start held high).
module tb_fft_stage_sequencer;

    localparam int LOG2_N     = 6;
    localparam int N          = 64;
    localparam int HALF_N     = 32;
    localparam int BF_LATENCY = 3;
    localparam int STAGE_CYC  = HALF_N + BF_LATENCY;
`ifdef FFT_SEQ_BITREV_EN
    localparam int LOAD_CYC = N;
`else
    localparam int LOAD_CYC = 0;
`endif

    logic        tb_clk = 1'b0;
    logic        reset, start, stall;
    logic        iteration_strobe, stage_strobe, bank_sel, busy, done;
    logic [4:0]  iteration_count, twiddle_idx;
    logic [2:0]  stage_count;
    logic [5:0]  addr_a, addr_b;
`ifdef FFT_SEQ_BITREV_EN
    logic        load_strobe;
    logic [5:0]  load_addr;
`endif

    fft_stage_sequencer #(.LOG2_N(LOG2_N), .BF_LATENCY(BF_LATENCY)) dut (
        .clk              (tb_clk),
        .reset            (reset),
        .start            (start),
        .stall            (stall),
        .iteration_strobe (iteration_strobe),
        .iteration_count  (iteration_count),
        .stage_count      (stage_count),
        .stage_strobe     (stage_strobe),
        .addr_a           (addr_a),
        .addr_b           (addr_b),
        .twiddle_idx      (twiddle_idx),
        .bank_sel         (bank_sel),
        .busy             (busy),
        .done             (done)
`ifdef FFT_SEQ_BITREV_EN
        ,
        .load_strobe      (load_strobe),
        .load_addr        (load_addr)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        int s;
        int i;
        int a;
        int b;
        int tw;
    } addr_vec_t;

    int tests = 0;
    int fails = 0;
    int exp_bank = 0;
    int obs_a [LOG2_N][HALF_N];
    int obs_b [LOG2_N][HALF_N];
    int obs_tw[LOG2_N][HALF_N];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < LOG2_N; b++) r |= ((k >> b) & 1) << (LOG2_N - 1 - b);
        return r;
    endfunction

    // One transform, counted in cycles after the start edge (cycle 1 is the first).
    task automatic run_transform(input bit stall_mode, input bit hold_start);
        int n = 0, exp_i = 0, exp_s = 0, stall_left = 0, load_k = 0, done_n = 0;
        int ss_idx = 0, extra;
        bit stall_used = 0, first_strobe = 1;
        int stb_cnt[LOG2_N];
        int ss_n[LOG2_N];
        foreach (stb_cnt[k]) begin stb_cnt[k] = 0; ss_n[k] = -1; end
`ifdef FFT_SEQ_BITREV_EN
        exp_bank = 0;
`endif
        @(negedge tb_clk); start = 1'b1; stall = 1'b0;
        @(posedge tb_clk);
        while (done_n == 0 && n < 600) begin
            @(negedge tb_clk);
            n++;
            if (!hold_start) start = 1'b0;
            stall = 1'b0;
            if (stall_mode) begin
                if (stall_left > 0) begin
                    stall = 1'b1; stall_left--;
                end else if (!stall_used && busy && stage_count == 1 && iteration_count == 7) begin
                    stall = 1'b1; stall_left = 3; stall_used = 1;
                end else if (stage_count == 3 && stb_cnt[3] == HALF_N) begin
                    stall = 1'b1;
                end
            end
            #1;
            if (stall) check("stall_blocks_strobe", iteration_strobe, 0);
            if (stall && stage_count == 1) check("stall_i_hold", iteration_count, 7);
`ifdef FFT_SEQ_BITREV_EN
            if (load_strobe) begin
                check("load_addr", load_addr, bitrev(load_k));
                load_k++;
            end
`endif
            if (iteration_strobe) begin
                if (first_strobe) check("loads_before_issue", load_k, LOAD_CYC);
                first_strobe = 0;
                check("iter_count", iteration_count, exp_i);
                check("stage_count", stage_count, exp_s);
                check("bank_sel_issue", bank_sel, exp_bank);
                if (exp_s < LOG2_N) begin
                    obs_a[exp_s][exp_i]  = addr_a;
                    obs_b[exp_s][exp_i]  = addr_b;
                    obs_tw[exp_s][exp_i] = twiddle_idx;
                    stb_cnt[exp_s]++;
                end
                exp_i = (exp_i + 1) % HALF_N;
            end
            if (stage_strobe) begin
                if (ss_idx < LOG2_N) ss_n[ss_idx] = n;
                ss_idx++;
                exp_s++;
                exp_bank ^= 1;
            end
            if (done) begin
                done_n = n;
                check("done_busy_low", busy, 0);
                check("done_no_strobe", iteration_strobe, 0);
                check("done_stage_count", stage_count, LOG2_N);
                check("done_bank_sel", bank_sel, exp_bank);
            end
        end
        if (done_n == 0) check("done_timeout", 0, 1);
        extra = stall_mode ? 4 : 0;
        check("done_cycle", done_n, LOAD_CYC + LOG2_N * STAGE_CYC + 1 + extra);
        check("stage_strobe_count", ss_idx, LOG2_N);
        for (int k = 0; k < LOG2_N; k++) begin
            check("stage_strobe_cycle", ss_n[k],
                  LOAD_CYC + (k + 1) * STAGE_CYC + ((stall_mode && k >= 1) ? 4 : 0));
            check("strobes_per_stage", stb_cnt[k], HALF_N);
        end
        if (!hold_start) begin
            @(negedge tb_clk); #1;
            check("after_done_pulse", done, 0);
            check("after_done_busy", busy, 0);
            check("final_stage_held", stage_count, LOG2_N);
            check("final_bank_held", bank_sel, exp_bank);
        end
    endtask

    initial begin
        addr_vec_t vecs[8];
        bit found;
        vecs[0] = '{s: 0, i: 0,  a: 0,  b: 1,  tw: 0};
        vecs[1] = '{s: 0, i: 5,  a: 10, b: 11, tw: 0};
        vecs[2] = '{s: 5, i: 5,  a: 5,  b: 37, tw: 5};
        vecs[3] = '{s: 2, i: 6,  a: 10, b: 14, tw: 16};
        vecs[4] = '{s: 1, i: 7,  a: 13, b: 15, tw: 16};
        vecs[5] = '{s: 5, i: 31, a: 31, b: 63, tw: 31};
        vecs[6] = '{s: 3, i: 13, a: 21, b: 29, tw: 20};
        vecs[7] = '{s: 4, i: 31, a: 47, b: 63, tw: 30};
        foreach (obs_a[s, i]) begin obs_a[s][i] = -1; obs_b[s][i] = -1; obs_tw[s][i] = -1; end

        reset = 1'b1; start = 1'b0; stall = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_iter_strobe", iteration_strobe, 0);
        check("rst_stage_strobe", stage_strobe, 0);
        check("rst_iter_count", iteration_count, 0);
        check("rst_stage_count", stage_count, 0);
        check("rst_bank_sel", bank_sel, 0);
        @(negedge tb_clk); reset = 1'b0;

        // stall alone in IDLE must not start anything
        stall = 1'b1;
        repeat (3) begin
            @(negedge tb_clk); #1;
            check("idle_stall_busy", busy, 0);
            check("idle_stall_strobe", iteration_strobe, 0);
        end
        stall = 1'b0;

        run_transform(1'b0, 1'b0);
        foreach (vecs[k]) begin
            check("vec_addr_a", obs_a[vecs[k].s][vecs[k].i], vecs[k].a);
            check("vec_addr_b", obs_b[vecs[k].s][vecs[k].i], vecs[k].b);
            check("vec_twiddle", obs_tw[vecs[k].s][vecs[k].i], vecs[k].tw);
        end

        run_transform(1'b1, 1'b0);

        // Reset in the middle of stage 2, iteration 10, with start also high
        @(negedge tb_clk); start = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk); start = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge tb_clk); #1;
            if (iteration_strobe && stage_count == 2 && iteration_count == 10) found = 1;
        end
        check("reach_s2_i10", found, 1);
        #2; reset = 1'b1; start = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_iter_strobe", iteration_strobe, 0);
        check("midrst_iter_count", iteration_count, 0);
        check("midrst_stage_count", stage_count, 0);
        check("midrst_bank_sel", bank_sel, 0);
        check("midrst_addr_b", addr_b, 0);
        @(negedge tb_clk); #1;
        check("reset_beats_start", busy, 0);
        reset = 1'b0; start = 1'b0; exp_bank = 0;
        run_transform(1'b0, 1'b0);

        // start held high for the whole transform and beyond
        run_transform(1'b0, 1'b1);
        @(negedge tb_clk); #1;
        check("held_idle_busy", busy, 0);
        check("held_idle_done", done, 0);
        @(negedge tb_clk); #1;
        check("held_restart_busy", busy, 1);
        check("held_restart_stage", stage_count, 0);
`ifdef FFT_SEQ_BITREV_EN
        check("held_restart_load", load_strobe, 1);
        check("held_restart_laddr", load_addr, 0);
`else
        check("held_restart_strobe", iteration_strobe, 1);
        check("held_restart_iter", iteration_count, 0);
`endif
        start = 1'b0;
        reset = 1'b1;
        @(negedge tb_clk); reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
